// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding and
// the default bit period.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 104;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable
// reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-byte holding register with
// valid/ready handoff, and framing-error / overrun pulses.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    logic        rx_s;
    rx_state_e   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        expire;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_i),
        .q     (rx_s)
    );

    assign expire = (cnt == 16'd0);
    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 16'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            // Consumer handshake; a delivery below in the same cycle re-sets valid.
            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;
            if (state != ST_IDLE && state != ST_WAIT_IDLE && !expire)
                cnt <= cnt - 16'd1;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF_LOAD;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt     <= BIT_LOAD;
                            bit_idx <= 3'd0;
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (expire) begin
                        if (rx_s) begin
                            // Leaving at mid-stop lets the next start edge be caught early.
                            state <= ST_IDLE;
                            if (!rx_valid_o || rx_ready_i) begin
                                rx_data_o  <= shreg;
                                rx_valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized scoreboard bench for uart_byte_rx at CLKS_PER_BIT=8: a line-level
// model predicts delivered bytes and error pulses; a monitor checks handshakes.
module tb_uart_byte_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b1;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int  exp_ferr = 0, exp_ovr = 0;
    int  act_ferr = 0, act_ovr = 0;
    bit  model_held = 1'b0;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte is compared with the oldest prediction.
    always @(negedge clk) begin
        if (frame_err_o) act_ferr++;
        if (overrun_o)   act_ovr++;
        if (rx_valid_o && rx_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_data_o);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data_o !== e) begin
                    errors++;
                    $display("FAIL rx_byte: got %0h expected %0h", rx_data_o, e);
                end
            end
        end
    end

    // Behavioural outcome of one complete frame as seen by the consumer.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)
            exp_ferr++;
        else if (!rx_ready_i && model_held)
            exp_ovr++;
        else begin
            exp_q.push_back(b);
            if (!rx_ready_i) model_held = 1'b1;
        end
    endtask

    // All line tasks start and end 1 time unit after a rising edge.
    task automatic hold(input logic v, input int n);
        rx_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_frame(b, stop_ok);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_ok, CPB);
    endtask

    task automatic set_ready(input logic r);
        rx_ready_i = r;
        if (r) model_held = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy_o,      0);
        check({tag, "_valid"}, rx_valid_o,  0);
        check({tag, "_data"},  rx_data_o,   0);
        check({tag, "_ferr"},  frame_err_o, 0);
        check({tag, "_ovr"},   overrun_o,   0);
    endtask

    initial begin
        int t0, lat;
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        hold(1'b1, 4);

        // 0xA5 with latency: 2 sync cycles + 77 from start detection.
        t0 = cyc;
        lat = -1;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (rx_valid_o) begin lat = cyc - t0; break; end
                end
            end
        join
        check("a5_latency", lat, 2 + CPB/2 + 9*CPB + 1);
        hold(1'b1, 8);

        // Overrun: second byte dropped, first held stable.
        set_ready(1'b0);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
        hold(1'b1, 6);
        check("ovr_data", rx_data_o, 8'h3C);
        check("ovr_valid", rx_valid_o, 1);
        check("ovr_count", act_ovr, exp_ovr);
        set_ready(1'b1);
        hold(1'b1, 4);

        // Back-to-back frames, no idle gap.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        hold(1'b1, 8);
        check("b2b_drained", exp_q.size(), 0);

        // Short low glitch is ignored.
        hold(1'b0, 3);
        hold(1'b1, 20);
        check("glitch_busy", busy_o, 0);
        check("glitch_valid", rx_valid_o, 0);

        // Bad stop bit followed by a break, then a good byte.
        send_byte(8'h81, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 16);
        check("break_ferr", act_ferr, exp_ferr);
        send_byte(8'h42, 1'b1);
        hold(1'b1, 8);

        // Reset in the middle of data bit 4 of 0x5A.
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(i[0], CPB);
        hold(1'b1, CPB/2);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 16);
        send_byte(8'h99, 1'b1);
        hold(1'b1, 8);

        // Random bytes, occasional bad stop bits, random gaps.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            bit ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 7) != 0);
            send_byte(b, ok);
            hold(1'b1, ok ? $urandom_range(0, 20) : $urandom_range(8, 20));
        end

        hold(1'b1, 30);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_ferr", act_ferr, exp_ferr);
        check("final_ovr", act_ovr, exp_ovr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, giving clocks per UART bit period (legal range 4..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port rx_i, input, 1, the raw asynchronous serial line (8N1, idle high, LSB first).
REQ-005 The block SHALL have port rx_data_o, output, 8, the received byte in the holding register.
REQ-006 The block SHALL have port rx_valid_o, output, 1, meaning the holding register contains an undelivered byte.
REQ-007 The block SHALL have port rx_ready_i, input, 1, the consumer accepts the byte when it is high in the same cycle as rx_valid_o.
REQ-008 The block SHALL have port frame_err_o, output, 1, a one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port overrun_o, output, 1, a one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-010 The block SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-011 rx_i SHALL pass through a two-flop synchronizer whose flops reset to 1; all logic uses the synchronized value rx_s.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-013 IDLE: when rx_s=0, load the bit counter with CLKS_PER_BIT/2-1 (integer division) and go to START.
REQ-014 The counter SHALL decrement once per clock; "expiry" is the cycle the counter equals 0, and rx_s is sampled on that cycle.
REQ-015 START at expiry: if rx_s=1, treat it as a glitch and return to IDLE with no output; otherwise load CLKS_PER_BIT-1, clear the bit index, and go to DATA.
REQ-016 DATA at expiry: shift rx_s into bit [7] of the shift register (right-shift, so LSB first) and reload CLKS_PER_BIT-1; after the 8th bit (index 7), go to STOP.
REQ-017 STOP at expiry, rx_s=1: deliver the byte and go to IDLE on the next cycle, so a start bit is detectable from the middle of the stop bit onward.
REQ-018 Delivery SHALL load the holding register and set rx_valid_o on the next cycle if rx_valid_o=0, or if rx_valid_o and rx_ready_i are both high in the delivery cycle; in that case there is no overrun and rx_valid_o stays high.
REQ-019 Delivery with rx_valid_o=1 and rx_ready_i=0 SHALL discard the new byte, keep the held byte unchanged, and pulse overrun_o for one cycle.
REQ-020 STOP at expiry, rx_s=0: discard the byte, pulse frame_err_o for one cycle, and go to WAIT_IDLE.
REQ-021 WAIT_IDLE SHALL go to IDLE on the first cycle rx_s=1; a held-low break line therefore yields exactly one frame_err_o pulse.
REQ-022 rx_valid_o SHALL clear on the cycle after rx_valid_o&rx_ready_i unless a simultaneous delivery occurs; rx_data_o is stable while rx_valid_o=1.
REQ-023 The latency from the first IDLE cycle seeing rx_s=0 to rx_valid_o rising SHALL be CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.

Reset
REQ-024 When rst_n=0, asynchronously: state=IDLE, counter=0, bit index=0, shift register=0, rx_data_o=0x00, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release the block waits in IDLE for a new falling edge.

Structure
REQ-026 The state enum and the default CLKS_PER_BIT constant SHALL reside in shared package uart_pkg.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameter set to 1).

Verification (CLKS_PER_BIT=8)
REQ-028 Send byte 0xA5 with rx_ready_i=1 -> rx_data_o=0xA5, one-cycle rx_valid_o rising 77 cycles after start detection, no error pulses.
REQ-029 Send 0x3C then 0xC3 with rx_ready_i=0 -> rx_data_o stays 0x3C, rx_valid_o stays 1, one overrun_o pulse at the second stop-sample+1.
REQ-030 Back-to-back 0x00, 0xFF, 0x55 with no idle gap and rx_ready_i=1 -> three bytes in order, no frame_err_o or overrun_o.
REQ-031 Low glitch of 3 cycles on rx_i -> return to IDLE, no rx_valid_o, no error pulses.
REQ-032 Frame 0x81 with stop bit 0, then line held low for 40 cycles -> exactly one frame_err_o pulse, no rx_valid_o; a following good 0x42 is received correctly.
REQ-033 Assert rst_n=0 during DATA bit 4 of a frame, then release and send 0x99 -> all outputs at their reset values, then 0x99 is received correctly.
